// File: rtl/pwm_pkg.sv
// Shared constants for the three-phase sine-triangle PWM lookup ROM:
// table geometry, phase lags and the centre-aligned triangular carrier.
package pwm_pkg;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int OFS2  = 85;
  localparam int OFS3  = 171;

  // One carrier period, rising then falling, so pulses come out centre-aligned.
  localparam logic [7:0] CARRIER [DW] = '{8'd32, 8'd96, 8'd160, 8'd224,
                                          8'd224, 8'd160, 8'd96, 8'd32};

  typedef struct packed {
    logic [DW-1:0] out3;
    logic [DW-1:0] out2;
    logic [DW-1:0] out1;
  } phase_bytes_t;

  function automatic logic [DW-1:0] carrier_cmp(input logic [7:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < DW; j++) begin
      r[j] = (s > CARRIER[j]);
    end
    return r;
  endfunction

endpackage

// File: rtl/sine_lut.sv
// 256-entry sine table, s[a] = floor(128 + 127*sin(2*pi*a/256) + 0.5).
// Purely combinational; the caller registers the derived result.
module sine_lut (
  input  logic [7:0] addr,
  output logic [7:0] s
);

  always_comb begin
    s = 8'd128;
    case (addr)
      8'd0: s = 8'd128;    8'd1: s = 8'd131;    8'd2: s = 8'd134;    8'd3: s = 8'd137;
      8'd4: s = 8'd140;    8'd5: s = 8'd144;    8'd6: s = 8'd147;    8'd7: s = 8'd150;
      8'd8: s = 8'd153;    8'd9: s = 8'd156;    8'd10: s = 8'd159;   8'd11: s = 8'd162;
      8'd12: s = 8'd165;   8'd13: s = 8'd168;   8'd14: s = 8'd171;   8'd15: s = 8'd174;
      8'd16: s = 8'd177;   8'd17: s = 8'd179;   8'd18: s = 8'd182;   8'd19: s = 8'd185;
      8'd20: s = 8'd188;   8'd21: s = 8'd191;   8'd22: s = 8'd193;   8'd23: s = 8'd196;
      8'd24: s = 8'd199;   8'd25: s = 8'd201;   8'd26: s = 8'd204;   8'd27: s = 8'd206;
      8'd28: s = 8'd209;   8'd29: s = 8'd211;   8'd30: s = 8'd213;   8'd31: s = 8'd216;
      8'd32: s = 8'd218;   8'd33: s = 8'd220;   8'd34: s = 8'd222;   8'd35: s = 8'd224;
      8'd36: s = 8'd226;   8'd37: s = 8'd228;   8'd38: s = 8'd230;   8'd39: s = 8'd232;
      8'd40: s = 8'd234;   8'd41: s = 8'd235;   8'd42: s = 8'd237;   8'd43: s = 8'd239;
      8'd44: s = 8'd240;   8'd45: s = 8'd241;   8'd46: s = 8'd243;   8'd47: s = 8'd244;
      8'd48: s = 8'd245;   8'd49: s = 8'd246;   8'd50: s = 8'd248;   8'd51: s = 8'd249;
      8'd52: s = 8'd250;   8'd53: s = 8'd250;   8'd54: s = 8'd251;   8'd55: s = 8'd252;
      8'd56: s = 8'd253;   8'd57: s = 8'd253;   8'd58: s = 8'd254;   8'd59: s = 8'd254;
      8'd60: s = 8'd254;   8'd61: s = 8'd255;   8'd62: s = 8'd255;   8'd63: s = 8'd255;
      8'd64: s = 8'd255;   8'd65: s = 8'd255;   8'd66: s = 8'd255;   8'd67: s = 8'd255;
      8'd68: s = 8'd254;   8'd69: s = 8'd254;   8'd70: s = 8'd254;   8'd71: s = 8'd253;
      8'd72: s = 8'd253;   8'd73: s = 8'd252;   8'd74: s = 8'd251;   8'd75: s = 8'd250;
      8'd76: s = 8'd250;   8'd77: s = 8'd249;   8'd78: s = 8'd248;   8'd79: s = 8'd246;
      8'd80: s = 8'd245;   8'd81: s = 8'd244;   8'd82: s = 8'd243;   8'd83: s = 8'd241;
      8'd84: s = 8'd240;   8'd85: s = 8'd239;   8'd86: s = 8'd237;   8'd87: s = 8'd235;
      8'd88: s = 8'd234;   8'd89: s = 8'd232;   8'd90: s = 8'd230;   8'd91: s = 8'd228;
      8'd92: s = 8'd226;   8'd93: s = 8'd224;   8'd94: s = 8'd222;   8'd95: s = 8'd220;
      8'd96: s = 8'd218;   8'd97: s = 8'd216;   8'd98: s = 8'd213;   8'd99: s = 8'd211;
      8'd100: s = 8'd209;  8'd101: s = 8'd206;  8'd102: s = 8'd204;  8'd103: s = 8'd201;
      8'd104: s = 8'd199;  8'd105: s = 8'd196;  8'd106: s = 8'd193;  8'd107: s = 8'd191;
      8'd108: s = 8'd188;  8'd109: s = 8'd185;  8'd110: s = 8'd182;  8'd111: s = 8'd179;
      8'd112: s = 8'd177;  8'd113: s = 8'd174;  8'd114: s = 8'd171;  8'd115: s = 8'd168;
      8'd116: s = 8'd165;  8'd117: s = 8'd162;  8'd118: s = 8'd159;  8'd119: s = 8'd156;
      8'd120: s = 8'd153;  8'd121: s = 8'd150;  8'd122: s = 8'd147;  8'd123: s = 8'd144;
      8'd124: s = 8'd140;  8'd125: s = 8'd137;  8'd126: s = 8'd134;  8'd127: s = 8'd131;
      8'd128: s = 8'd128;  8'd129: s = 8'd125;  8'd130: s = 8'd122;  8'd131: s = 8'd119;
      8'd132: s = 8'd116;  8'd133: s = 8'd112;  8'd134: s = 8'd109;  8'd135: s = 8'd106;
      8'd136: s = 8'd103;  8'd137: s = 8'd100;  8'd138: s = 8'd97;   8'd139: s = 8'd94;
      8'd140: s = 8'd91;   8'd141: s = 8'd88;   8'd142: s = 8'd85;   8'd143: s = 8'd82;
      8'd144: s = 8'd79;   8'd145: s = 8'd77;   8'd146: s = 8'd74;   8'd147: s = 8'd71;
      8'd148: s = 8'd68;   8'd149: s = 8'd65;   8'd150: s = 8'd63;   8'd151: s = 8'd60;
      8'd152: s = 8'd57;   8'd153: s = 8'd55;   8'd154: s = 8'd52;   8'd155: s = 8'd50;
      8'd156: s = 8'd47;   8'd157: s = 8'd45;   8'd158: s = 8'd43;   8'd159: s = 8'd40;
      8'd160: s = 8'd38;   8'd161: s = 8'd36;   8'd162: s = 8'd34;   8'd163: s = 8'd32;
      8'd164: s = 8'd30;   8'd165: s = 8'd28;   8'd166: s = 8'd26;   8'd167: s = 8'd24;
      8'd168: s = 8'd22;   8'd169: s = 8'd21;   8'd170: s = 8'd19;   8'd171: s = 8'd17;
      8'd172: s = 8'd16;   8'd173: s = 8'd15;   8'd174: s = 8'd13;   8'd175: s = 8'd12;
      8'd176: s = 8'd11;   8'd177: s = 8'd10;   8'd178: s = 8'd8;    8'd179: s = 8'd7;
      8'd180: s = 8'd6;    8'd181: s = 8'd6;    8'd182: s = 8'd5;    8'd183: s = 8'd4;
      8'd184: s = 8'd3;    8'd185: s = 8'd3;    8'd186: s = 8'd2;    8'd187: s = 8'd2;
      8'd188: s = 8'd2;    8'd189: s = 8'd1;    8'd190: s = 8'd1;    8'd191: s = 8'd1;
      8'd192: s = 8'd1;    8'd193: s = 8'd1;    8'd194: s = 8'd1;    8'd195: s = 8'd1;
      8'd196: s = 8'd2;    8'd197: s = 8'd2;    8'd198: s = 8'd2;    8'd199: s = 8'd3;
      8'd200: s = 8'd3;    8'd201: s = 8'd4;    8'd202: s = 8'd5;    8'd203: s = 8'd6;
      8'd204: s = 8'd6;    8'd205: s = 8'd7;    8'd206: s = 8'd8;    8'd207: s = 8'd10;
      8'd208: s = 8'd11;   8'd209: s = 8'd12;   8'd210: s = 8'd13;   8'd211: s = 8'd15;
      8'd212: s = 8'd16;   8'd213: s = 8'd17;   8'd214: s = 8'd19;   8'd215: s = 8'd21;
      8'd216: s = 8'd22;   8'd217: s = 8'd24;   8'd218: s = 8'd26;   8'd219: s = 8'd28;
      8'd220: s = 8'd30;   8'd221: s = 8'd32;   8'd222: s = 8'd34;   8'd223: s = 8'd36;
      8'd224: s = 8'd38;   8'd225: s = 8'd40;   8'd226: s = 8'd43;   8'd227: s = 8'd45;
      8'd228: s = 8'd47;   8'd229: s = 8'd50;   8'd230: s = 8'd52;   8'd231: s = 8'd55;
      8'd232: s = 8'd57;   8'd233: s = 8'd60;   8'd234: s = 8'd63;   8'd235: s = 8'd65;
      8'd236: s = 8'd68;   8'd237: s = 8'd71;   8'd238: s = 8'd74;   8'd239: s = 8'd77;
      8'd240: s = 8'd79;   8'd241: s = 8'd82;   8'd242: s = 8'd85;   8'd243: s = 8'd88;
      8'd244: s = 8'd91;   8'd245: s = 8'd94;   8'd246: s = 8'd97;   8'd247: s = 8'd100;
      8'd248: s = 8'd103;  8'd249: s = 8'd106;  8'd250: s = 8'd109;  8'd251: s = 8'd112;
      8'd252: s = 8'd116;  8'd253: s = 8'd119;  8'd254: s = 8'd122;  8'd255: s = 8'd125;
      default: s = 8'd128;
    endcase
  end

endmodule

// File: rtl/rom.sv
// Three-phase PWM lookup ROM: one sine lookup per phase, carrier compare,
// and a single registered stage so addr never reaches the outputs combinationally.
module rom
  import pwm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3
);

  // Lagging by OFS is the same as leading by DEPTH-OFS; the 8-bit add wraps naturally.
  localparam logic [AW-1:0] PH2_STEP = AW'(DEPTH - OFS2);
  localparam logic [AW-1:0] PH3_STEP = AW'(DEPTH - OFS3);

  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;
  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    s3;
  phase_bytes_t  bytes_d;
  phase_bytes_t  bytes_q;

  always_comb begin
    a1 = addr;
    a2 = addr + PH2_STEP;
    a3 = addr + PH3_STEP;
  end

  sine_lut u_sine1 (.addr(a1), .s(s1));
  sine_lut u_sine2 (.addr(a2), .s(s2));
  sine_lut u_sine3 (.addr(a3), .s(s3));

  always_comb begin
    bytes_d      = '0;
    bytes_d.out1 = carrier_cmp(s1);
    bytes_d.out2 = carrier_cmp(s2);
    bytes_d.out3 = carrier_cmp(s3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bytes_q <= '0;
    end else begin
      bytes_q <= bytes_d;
    end
  end

  assign out1 = bytes_q.out1;
  assign out2 = bytes_q.out2;
  assign out3 = bytes_q.out3;

endmodule

// File: tb/tb_rom.sv
// Bench for the three-phase PWM lookup ROM: directed points, full sweeps with wrap,
// mid-sweep reset and random addressing against a real-arithmetic sine model.
module tb_rom;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] out1;
  logic [7:0] out2;
  logic [7:0] out3;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  sw1 [256];
  logic [7:0]  sw2 [256];
  logic [7:0]  sw3 [256];

  rom dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int model_sine(input int a);
    real pi_v;
    pi_v = 3.14159265358979323846;
    return int'($floor(128.0 + 127.0 * $sin(2.0 * pi_v * real'(a) / 256.0) + 0.5));
  endfunction

  function automatic logic [7:0] model_byte(input int a);
    int         c[8];
    int         sv;
    logic [7:0] b;
    c  = '{32, 96, 160, 224, 224, 160, 96, 32};
    sv = model_sine(((a % 256) + 256) % 256);
    b  = '0;
    for (int j = 0; j < 8; j++) b[j] = (sv > c[j]);
    return b;
  endfunction

  function automatic logic [23:0] model_word(input int a);
    return {model_byte(a - 171), model_byte(a - 85), model_byte(a)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_shape(input string tag, input logic [7:0] got);
    total++;
    assert (got === 8'h00 || got === 8'h81 || got === 8'hC3 || got === 8'hE7 || got === 8'hFF)
    else begin
      bad++;
      $error("FAIL %s: got %h expected one of 00/81/C3/E7/FF", tag, got);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] a, input logic r, input string tag);
    logic [23:0] e;
    @(negedge clk);
    addr  = a;
    rst_n = r;
    exp_q.push_back(r ? model_word(int'(a)) : 24'h0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check8({tag, "_out1"}, out1, e[7:0]);
    check8({tag, "_out2"}, out2, e[15:8]);
    check8({tag, "_out3"}, out3, e[23:16]);
    check_shape({tag, "_shape1"}, out1);
    check_shape({tag, "_shape2"}, out2);
    check_shape({tag, "_shape3"}, out3);
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = 8'd64;

    // reset for two clocks with addr parked at the sine peak
    step(8'd64, 1'b0, "reset0");
    step(8'd64, 1'b0, "reset1");
    step(8'd64, 1'b1, "release");
    check8("release_peak", out1, 8'hFF);

    // directed points
    step(8'd0, 1'b1, "addr0");
    check8("addr0_o1", out1, 8'hC3);
    check8("addr0_o2", out2, 8'h00);
    check8("addr0_o3", out3, 8'hFF);
    step(8'd64, 1'b1, "addr64");
    check8("addr64_o1", out1, 8'hFF);
    check8("addr64_o2", out2, 8'h81);
    check8("addr64_o3", out3, 8'h81);
    step(8'd192, 1'b1, "addr192");
    check8("addr192_o1", out1, 8'h00);
    check8("addr192_o2", out2, 8'hE7);
    check8("addr192_o3", out3, 8'hE7);

    // first full sweep, recording what comes out
    for (int i = 0; i < 256; i++) begin
      step(8'(i), 1'b1, "sweep1");
      sw1[i] = out1;
      sw2[i] = out2;
      sw3[i] = out3;
    end

    // second sweep through the wrap must repeat the first exactly
    for (int i = 0; i < 257; i++) begin
      step(8'(i % 256), 1'b1, "sweep2");
      check8("repeat_o1", out1, sw1[i % 256]);
      check8("repeat_o2", out2, sw2[i % 256]);
      check8("repeat_o3", out3, sw3[i % 256]);
    end

    // phase relationship: phase 2 at a+85 and phase 3 at a+171 replay phase 1 at a
    for (int a = 0; a < 256; a++) begin
      check8("sym_p2", sw2[(a + 85) % 256], sw1[a]);
      check8("sym_p3", sw3[(a + 171) % 256], sw1[a]);
    end

    // reset in the middle of a sweep, then resume at the same address
    for (int i = 90; i <= 110; i++) begin
      if (i == 100) begin
        step(8'd100, 1'b0, "mid_reset");
        check8("mid_reset_o1", out1, 8'h00);
        step(8'd100, 1'b1, "mid_resume");
      end else begin
        step(8'(i), 1'b1, "mid_sweep");
      end
    end

    // random addressing with occasional resets
    for (int n = 0; n < 400; n++) begin
      step(8'($urandom_range(0, 255)), ($urandom_range(0, 15) != 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
